// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM encoding, byte-enable patterns and request decode helpers.
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } lsu_state_e;

  // Exactly one op kind, a known width code, and natural alignment.
  function automatic logic req_legal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic code_ok;
    logic width_ok;
    code_ok = ld ? !(f3[2] && f3[1]) : !f3[2];
    case (f3[1:0])
      2'b00:   width_ok = 1'b1;
      2'b01:   width_ok = !lo[0];
      2'b10:   width_ok = (lo == 2'b00);
      default: width_ok = 1'b0;
    endcase
    return (ld ^ st) && code_ok && width_ok;
  endfunction

  function automatic logic [3:0] byte_en_of(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    case (f3[1:0])
      2'b00:   return BE_B << lo;
      2'b01:   return BE_H << lo;
      default: return BE_W;
    endcase
  endfunction

  function automatic logic [31:0] w_data_of(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Read lane extraction: shift the memory word down to the
// addressed byte, then sign- or zero-extend by funct3.
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] r_data,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = r_data >> {byte_off, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'd0, shifted[7:0]};
      F3_LHU:  data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes an RV32I memory op,
// drives a fixed-latency word memory and returns the aligned result.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [31:0]       offset,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_w_data,
  output logic              mem_w_en,
  input  logic [31:0]       mem_r_data
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  logic [31:0]       ld_q, ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;

  logic [31:0] ea;
  logic        legal;
  logic [31:0] aligned;
  logic        unused_ea_hi;

  assign ea           = base + offset;
  assign legal        = req_legal(op_load, op_store, funct3, ea[1:0]);
  assign unused_ea_hi = ^ea[31:ADDR_W+2];

  lsu_align u_align (
    .r_data   (mem_r_data),
    .byte_off (off_q),
    .funct3   (f3_q),
    .data     (aligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    f3_d    = f3_q;
    off_d   = off_q;
    err_d   = err_q;
    ld_d    = ld_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = !legal;
          if (legal) begin
            store_d = op_store;
            f3_d    = funct3;
            off_d   = ea[1:0];
            addr_d  = ea[ADDR_W+1:2];
            be_d    = byte_en_of(funct3, ea[1:0]);
            wd_d    = w_data_of(funct3, store_data);
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (store_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          ld_d    = aligned;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign load_data   = ld_q;
  assign mem_addr    = addr_q;
  assign mem_byte_en = be_q;
  assign mem_w_data  = wd_q;
  assign mem_w_en    = (state_q == S_ISSUE) && store_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a two-stage
// registered word memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op_load = 1'b0;
  logic        op_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] base = '0;
  logic [31:0] offset = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, err, mem_w_en;
  logic [31:0] load_data, mem_w_data, mem_r_data;
  logic [15:0] mem_addr;
  logic [3:0]  mem_byte_en;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:65535];
  logic [15:0] addr_r = '0;
  logic [31:0] q_r = '0;

  logic [15:0] c1_addr;
  logic [3:0]  c1_be;
  logic [31:0] c1_wd;
  logic        c1_we;
  int          dcyc;

  assign mem_r_data = q_r;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_load     (op_load),
    .op_store    (op_store),
    .funct3      (funct3),
    .base        (base),
    .offset      (offset),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .load_data   (load_data),
    .mem_addr    (mem_addr),
    .mem_byte_en (mem_byte_en),
    .mem_w_data  (mem_w_data),
    .mem_w_en    (mem_w_en),
    .mem_r_data  (mem_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mem[mem_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
      we_cnt <= we_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    addr_r <= mem_addr;
    q_r    <= mem[addr_r];
  end

  task automatic run_req(
    input logic        ld,
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] b,
    input logic [31:0] o,
    input logic [31:0] d
  );
    @(negedge clk);
    op_load = ld; op_store = st; funct3 = f3;
    base = b; offset = o; store_data = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        c1_addr = mem_addr; c1_be = mem_byte_en;
        c1_wd = mem_w_data; c1_we = mem_w_en;
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    if (dcyc < 0) begin
      total++; bad++;
      $display("FAIL done_timeout got=none exp=done within 12 cycles");
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rst_ld got=%h exp=0", load_data); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if (mem_byte_en !== 4'h0) begin bad++; $display("FAIL rst_be got=%h exp=0", mem_byte_en); end
    total++; if (mem_w_data !== 32'h0) begin bad++; $display("FAIL rst_wd got=%h exp=0", mem_w_data); end
    total++; if (mem_w_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_w_en); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sw_lw();
    run_req(1'b0, 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF);
    total++; if (c1_addr !== 16'h41) begin bad++; $display("FAIL sw_addr got=%h exp=41", c1_addr); end
    total++; if (c1_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", c1_be); end
    total++; if (c1_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wd got=%h exp=deadbeef", c1_wd); end
    total++; if (c1_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", c1_we); end
    total++; if (dcyc != 2) begin bad++; $display("FAIL sw_lat got=%0d exp=2", dcyc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sw_err got=%b exp=0", err); end
    run_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h4, 32'h0);
    total++; if (c1_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b exp=0", c1_we); end
    total++; if (dcyc != 4) begin bad++; $display("FAIL lw_lat got=%0d exp=4", dcyc); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", load_data); end
  endtask

  task automatic test_sb_lb();
    run_req(1'b0, 1'b1, 3'b000, 32'h100, 32'h3, 32'h80);
    total++; if (c1_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", c1_be); end
    total++; if (c1_wd !== 32'h80808080) begin bad++; $display("FAIL sb_wd got=%h exp=80808080", c1_wd); end
    total++; if (c1_addr !== 16'h40) begin bad++; $display("FAIL sb_addr got=%h exp=40", c1_addr); end
    total++; if (dcyc != 2) begin bad++; $display("FAIL sb_lat got=%0d exp=2", dcyc); end
    run_req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0);
    total++; if (load_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", load_data); end
    run_req(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0);
    total++; if (load_data !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", load_data); end
    run_req(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0);
    total++; if (load_data !== 32'h00008000) begin bad++; $display("FAIL lhu_data got=%h exp=00008000", load_data); end
    run_req(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0);
    total++; if (load_data !== 32'hFFFF8000) begin bad++; $display("FAIL lh_data got=%h exp=ffff8000", load_data); end
    run_req(1'b0, 1'b1, 3'b001, 32'h200, 32'h2, 32'h0000A5C3);
    total++; if (c1_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", c1_be); end
    total++; if (c1_wd !== 32'hA5C3A5C3) begin bad++; $display("FAIL sh_wd got=%h exp=a5c3a5c3", c1_wd); end
  endtask

  task automatic test_illegal();
    int we0;
    we0 = we_cnt;
    run_req(1'b1, 1'b0, 3'b001, 32'h100, 32'h1, 32'h0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL lh_mis_err got=%b exp=1", err); end
    total++; if (dcyc != 1) begin bad++; $display("FAIL lh_mis_lat got=%0d exp=1", dcyc); end
    total++; if (load_data !== 32'hFFFF8000) begin bad++; $display("FAIL err_ld_hold got=%h exp=ffff8000", load_data); end
    run_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL f3_011_err got=%b exp=1", err); end
    run_req(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL both_op_err got=%b exp=1", err); end
    run_req(1'b0, 1'b1, 3'b010, 32'h100, 32'h2, 32'h1234);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sw_mis_err got=%b exp=1", err); end
    run_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h1234);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL st_f3_err got=%b exp=1", err); end
    total++; if (we_cnt != we0) begin bad++; $display("FAIL err_no_write got=%0d exp=%0d", we_cnt, we0); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", err); end
  endtask

  task automatic test_busy_lockout();
    int d0;
    int c;
    d0 = done_cnt;
    @(negedge clk);
    op_load = 1'b1; op_store = 1'b0; funct3 = 3'b010;
    base = 32'h104; offset = 32'h0; start = 1'b1;
    c = 0;
    while (!(c > 0 && done) && c < 12) begin
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    total++; if (c != 4) begin bad++; $display("FAIL lock_lat got=%0d exp=4", c); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL lock_err got=%b exp=0", err); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lock_data got=%h exp=deadbeef", load_data); end
    @(posedge clk); #1;
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL lock_count got=%0d exp=1", done_cnt - d0); end
    run_req(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA);
    total++; if (dcyc != 2) begin bad++; $display("FAIL b2b_lat got=%0d exp=2", dcyc); end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk);
    op_load = 1'b0; op_store = 1'b1; funct3 = 3'b010;
    base = 32'h400; offset = 32'h0; store_data = 32'h12345678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++; if (mem_w_en !== 1'b1) begin bad++; $display("FAIL mid_issue_we got=%b exp=1", mem_w_en); end
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_w_en !== 1'b0) begin bad++; $display("FAIL mid_we_drop got=%b exp=0", mem_w_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", mem_addr); end
    repeat (3) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, d0); end
    rst = 1'b1;
    run_req(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0);
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL mid_no_write got=%h exp=0", load_data); end
    run_req(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0);
    @(negedge clk);
    op_load = 1'b1; op_store = 1'b0; funct3 = 3'b010;
    base = 32'h100; offset = 32'h4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL wait_rst_ld got=%h exp=0", load_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wait_rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    run_req(1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D);
    total++; if (c1_addr !== 16'h1) begin bad++; $display("FAIL wrap_addr got=%h exp=1", c1_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", err); end
    run_req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0);
    total++; if (load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_ld got=%h exp=cafef00d", load_data); end
    run_req(1'b0, 1'b1, 3'b010, 32'h0004_0000, 32'h10, 32'h0BADF00D);
    total++; if (c1_addr !== 16'h4) begin bad++; $display("FAIL hi_wrap_addr got=%h exp=4", c1_addr); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    test_reset();
    test_sw_lw();
    test_sb_lb();
    test_illegal();
    test_busy_lockout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
